// File: rtl/nx_indirect_access_initiator.sv
// Register-bus initiator for the indirect-access protocol: writes data words and CMND,
// polls STAT until not BUSY, then reads data words back for successful READs.
module nx_indirect_access_initiator #(
    parameter int CMND_ADDRESS    = 0,
    parameter int STAT_ADDRESS    = 0,
    parameter int DATA_ADDRESS    = 0,
    parameter int ALIGNMENT       = 2,
    parameter int N_REG_ADDR_BITS = 16,
    parameter int N_DATA_BITS     = 32,
    parameter int N_ENTRIES       = 1,
    parameter int MAX_POLLS       = 16,
    parameter int POLL_GAP        = 0,
    localparam int AW             = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_req_valid,
    output logic                       o_req_ready,
    input  logic [3:0]                 i_req_op,
    input  logic [AW-1:0]              i_req_addr,
    input  logic [N_DATA_BITS-1:0]     i_req_wdat,
    output logic                       o_resp_valid,
    output logic [2:0]                 o_resp_code,
    output logic                       o_resp_timeout,
    output logic [N_DATA_BITS-1:0]     o_resp_rdat,
    output logic                       o_bus_cs,
    output logic                       o_bus_we,
    output logic [N_REG_ADDR_BITS-1:0] o_bus_addr,
    output logic [31:0]                o_bus_wdat,
    input  logic                       i_bus_ack,
    input  logic [31:0]                i_bus_rdat,
    output logic [2:0]                 o_dbg_state
);
    localparam int N_WORDS = N_DATA_BITS / 32;
    localparam int PW      = $clog2(MAX_POLLS + 1);
    localparam int WW      = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
    localparam int GW      = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_WR_DATA   = 3'd1;
    localparam logic [2:0] S_WR_CMND   = 3'd2;
    localparam logic [2:0] S_RD_STAT   = 3'd3;
    localparam logic [2:0] S_POLL_WAIT = 3'd4;
    localparam logic [2:0] S_RD_DATA   = 3'd5;
    localparam logic [2:0] S_GAP       = 3'd6;
    localparam logic [2:0] S_DONE      = 3'd7;

    localparam logic [3:0] OP_READ   = 4'd1;
    localparam logic [3:0] OP_WRITE  = 4'd2;
    localparam logic [2:0] CODE_OK   = 3'd1;
    localparam logic [2:0] CODE_BUSY = 3'd3;

    logic [2:0]                 r_state;
    logic [2:0]                 r_next;
    logic [3:0]                 r_op;
    logic [AW-1:0]              r_addr;
    logic [N_DATA_BITS-1:0]     r_wdat;
    logic [N_DATA_BITS-1:0]     r_rdat;
    logic [2:0]                 r_code;
    logic                       r_timeout;
    logic [PW-1:0]              r_polls;
    logic [WW-1:0]              r_word;
    logic [GW-1:0]              r_gap;
    logic                       r_bus_cs;
    logic                       r_bus_we;
    logic [N_REG_ADDR_BITS-1:0] r_bus_addr;
    logic [31:0]                r_bus_wdat;

    logic                       w_ack;
    logic                       w_last_word;
    logic [2:0]                 w_stat_code;
    logic [PW-1:0]              w_polls_nxt;
    logic [31:0]                w_cmnd;
    logic [N_REG_ADDR_BITS-1:0] w_word_addr;
    logic                       w_launch_we;
    logic [N_REG_ADDR_BITS-1:0] w_launch_addr;
    logic [31:0]                w_launch_wdat;

    // Acks only count while an access is actually outstanding.
    assign w_ack       = r_bus_cs & i_bus_ack;
    assign w_last_word = (r_word == WW'(N_WORDS - 1));
    assign w_stat_code = i_bus_rdat[31:29];
    assign w_polls_nxt = r_polls + 1'b1;
    assign w_cmnd      = {r_op, 28'd0} | 32'(r_addr);
    assign w_word_addr = N_REG_ADDR_BITS'(DATA_ADDRESS) + (N_REG_ADDR_BITS'(r_word) << ALIGNMENT);

    // Bus fields for the access launched when leaving GAP.
    always_comb begin
        w_launch_we   = 1'b0;
        w_launch_addr = N_REG_ADDR_BITS'(STAT_ADDRESS);
        w_launch_wdat = '0;
        case (r_next)
            S_WR_DATA: begin
                w_launch_we   = 1'b1;
                w_launch_addr = w_word_addr;
                w_launch_wdat = r_wdat[32*int'(r_word) +: 32];
            end
            S_WR_CMND: begin
                w_launch_we   = 1'b1;
                w_launch_addr = N_REG_ADDR_BITS'(CMND_ADDRESS);
                w_launch_wdat = w_cmnd;
            end
            S_RD_DATA: w_launch_addr = w_word_addr;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_next     <= S_IDLE;
            r_op       <= '0;
            r_addr     <= '0;
            r_wdat     <= '0;
            r_rdat     <= '0;
            r_code     <= '0;
            r_timeout  <= 1'b0;
            r_polls    <= '0;
            r_word     <= '0;
            r_gap      <= '0;
            r_bus_cs   <= 1'b0;
            r_bus_we   <= 1'b0;
            r_bus_addr <= '0;
            r_bus_wdat <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (i_req_valid) begin
                    r_op      <= i_req_op;
                    r_addr    <= i_req_addr;
                    r_wdat    <= i_req_wdat;
                    r_rdat    <= '0;
                    r_code    <= '0;
                    r_timeout <= 1'b0;
                    r_polls   <= '0;
                    r_word    <= '0;
                    r_bus_cs  <= 1'b1;
                    r_bus_we  <= 1'b1;
                    if (i_req_op == OP_WRITE) begin
                        r_bus_addr <= N_REG_ADDR_BITS'(DATA_ADDRESS);
                        r_bus_wdat <= i_req_wdat[31:0];
                        r_state    <= S_WR_DATA;
                    end else begin
                        r_bus_addr <= N_REG_ADDR_BITS'(CMND_ADDRESS);
                        r_bus_wdat <= {i_req_op, 28'd0} | 32'(i_req_addr);
                        r_state    <= S_WR_CMND;
                    end
                end
                S_WR_DATA: if (w_ack) begin
                    r_bus_cs <= 1'b0;
                    r_state  <= S_GAP;
                    if (w_last_word) begin
                        r_next <= S_WR_CMND;
                    end else begin
                        r_word <= r_word + 1'b1;
                        r_next <= S_WR_DATA;
                    end
                end
                S_WR_CMND: if (w_ack) begin
                    r_bus_cs <= 1'b0;
                    r_state  <= S_GAP;
                    r_next   <= S_RD_STAT;
                end
                S_RD_STAT: if (w_ack) begin
                    r_bus_cs <= 1'b0;
                    r_polls  <= w_polls_nxt;
                    r_code   <= w_stat_code;
                    r_next   <= S_RD_STAT;
                    if (w_stat_code == CODE_BUSY) begin
                        if (w_polls_nxt == PW'(MAX_POLLS)) begin
                            r_timeout <= 1'b1;
                            r_state   <= S_DONE;
                        end else if (POLL_GAP > 0) begin
                            r_gap   <= '0;
                            r_state <= S_POLL_WAIT;
                        end else begin
                            r_state <= S_GAP;
                        end
                    end else if (r_op == OP_READ && w_stat_code == CODE_OK) begin
                        r_word  <= '0;
                        r_next  <= S_RD_DATA;
                        r_state <= S_GAP;
                    end else begin
                        r_state <= S_DONE;
                    end
                end
                S_POLL_WAIT: begin
                    if (r_gap == GW'(POLL_GAP - 1)) r_state <= S_GAP;
                    else                            r_gap   <= r_gap + 1'b1;
                end
                S_RD_DATA: if (w_ack) begin
                    r_bus_cs                    <= 1'b0;
                    r_rdat[32*int'(r_word) +: 32] <= i_bus_rdat;
                    if (w_last_word) begin
                        r_state <= S_DONE;
                    end else begin
                        r_word  <= r_word + 1'b1;
                        r_next  <= S_RD_DATA;
                        r_state <= S_GAP;
                    end
                end
                S_GAP: begin
                    r_bus_cs   <= 1'b1;
                    r_bus_we   <= w_launch_we;
                    r_bus_addr <= w_launch_addr;
                    r_bus_wdat <= w_launch_wdat;
                    r_state    <= r_next;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_req_ready    = (r_state == S_IDLE);
    assign o_resp_valid   = (r_state == S_DONE);
    assign o_resp_code    = r_code;
    assign o_resp_timeout = r_timeout;
    assign o_resp_rdat    = r_rdat;
    assign o_bus_cs       = r_bus_cs;
    assign o_bus_we       = r_bus_we;
    assign o_bus_addr     = r_bus_addr;
    assign o_bus_wdat     = r_bus_wdat;
    assign o_dbg_state    = r_state;
endmodule

// File: tb/tb_nx_indirect_access_initiator.sv
// Bench for nx_indirect_access_initiator: a register responder checks bus accesses
// against an expected queue; responses are checked against a response queue.
module tb_nx_indirect_access_initiator;
  localparam int CMND_A = 'h10;
  localparam int STAT_A = 'h14;
  localparam int DATA_A = 'h20;
  localparam int DW     = 64;
  localparam int AW     = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic [3:0]    req_op = '0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdat = '0;
  logic          req_ready;
  logic          resp_valid;
  logic [2:0]    resp_code;
  logic          resp_timeout;
  logic [DW-1:0] resp_rdat;
  logic          bus_cs;
  logic          bus_we;
  logic [15:0]   bus_addr;
  logic [31:0]   bus_wdat;
  logic          bus_ack = 1'b0;
  logic [31:0]   bus_rdat = '0;
  logic [2:0]    dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [48:0] exp_q[$];       // {we, addr, wdat}
  logic [67:0] exp_resp_q[$];  // {code, timeout, rdat}
  logic [31:0] stat_q[$];
  int          delay_q[$];
  int          stat_cyc[$];
  logic [31:0] data_mem[2];
  logic [31:0] stat_default = 32'hA000_0000;

  nx_indirect_access_initiator #(
    .CMND_ADDRESS(CMND_A), .STAT_ADDRESS(STAT_A), .DATA_ADDRESS(DATA_A),
    .ALIGNMENT(2), .N_REG_ADDR_BITS(16), .N_DATA_BITS(DW), .N_ENTRIES(8),
    .MAX_POLLS(4), .POLL_GAP(2)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_op(req_op),
    .i_req_addr(req_addr), .i_req_wdat(req_wdat),
    .o_resp_valid(resp_valid), .o_resp_code(resp_code), .o_resp_timeout(resp_timeout),
    .o_resp_rdat(resp_rdat),
    .o_bus_cs(bus_cs), .o_bus_we(bus_we), .o_bus_addr(bus_addr), .o_bus_wdat(bus_wdat),
    .i_bus_ack(bus_ack), .i_bus_rdat(bus_rdat), .o_dbg_state(dbg_state)
  );

  // clock / reset block
  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // register responder: wait states from delay_q, STAT values from stat_q
  initial begin : responder
    logic        in_acc;
    logic        acked_prev;
    int          wait_cnt;
    int          cur_delay;
    logic [48:0] acc_fields;
    logic [48:0] e;
    in_acc = 0; acked_prev = 0; wait_cnt = 0; cur_delay = 0; acc_fields = '0;
    forever begin
      @(negedge clk or negedge rst_n);
      if (!rst_n) begin
        bus_ack = 0; in_acc = 0; acked_prev = 0; wait_cnt = 0;
      end else if (bus_cs) begin
        n_tests++;
        if (acked_prev) begin
          n_fail++;
          $display("FAIL bus_gap: bus_cs=1 in cycle after ack, required 0 (cyc %0d)", cyc);
        end
        if (!in_acc || acked_prev) begin
          in_acc = 1; wait_cnt = 0; acc_fields = {bus_we, bus_addr, bus_wdat};
          cur_delay = 0;
          if (delay_q.size() > 0) cur_delay = delay_q.pop_front();
        end else begin
          n_tests++;
          if ({bus_we, bus_addr, bus_wdat} !== acc_fields) begin
            n_fail++;
            $display("FAIL bus_stable: got %h required %h", {bus_we, bus_addr, bus_wdat}, acc_fields);
          end
        end
        if (wait_cnt >= cur_delay) begin
          bus_ack = 1; acked_prev = 1; in_acc = 0;
          if (!bus_we) begin
            if (bus_addr == 16'(STAT_A)) begin
              stat_cyc.push_back(cyc);
              bus_rdat = stat_default;
              if (stat_q.size() > 0) bus_rdat = stat_q.pop_front();
            end else if (bus_addr == 16'(DATA_A)) bus_rdat = data_mem[0];
            else if (bus_addr == 16'(DATA_A + 4)) bus_rdat = data_mem[1];
            else bus_rdat = $urandom;
          end
          n_tests++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL bus_access: unexpected we=%0d addr=%h wdat=%h, required none", bus_we, bus_addr, bus_wdat);
          end else begin
            e = exp_q.pop_front();
            if (bus_we !== e[48] || bus_addr !== e[47:32] || (bus_we && bus_wdat !== e[31:0])) begin
              n_fail++;
              $display("FAIL bus_access: got we=%0d addr=%h wdat=%h, required we=%0d addr=%h wdat=%h",
                       bus_we, bus_addr, bus_wdat, e[48], e[47:32], e[31:0]);
            end
          end
        end else begin
          bus_ack = 0; wait_cnt++; acked_prev = 0;
        end
      end else begin
        // noise while idle must be ignored by the initiator
        bus_ack = 1'($urandom_range(0, 1));
        bus_rdat = $urandom;
        in_acc = 0; acked_prev = 0;
      end
    end
  end

  // driver tasks
  task automatic push_acc(input logic we, input int addr, input logic [31:0] wdat);
    exp_q.push_back({we, 16'(addr), wdat});
  endtask

  task automatic send_req(input logic [3:0] op, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                          output int acc_cyc);
    int k;
    k = 0;
    @(negedge clk);
    while (!req_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    n_tests++;
    if (!req_ready) begin
      n_fail++;
      $display("FAIL req_ready_wait: req_ready=%0d, required 1", req_ready);
    end
    req_valid = 1; req_op = op; req_addr = a; req_wdat = wd;
    acc_cyc = cyc;
    @(posedge clk);
    #1 req_valid = 0;
    req_wdat = {$urandom, $urandom};
  endtask

  task automatic wait_resp(input int exp_cyc);
    logic        seen;
    logic        busy_ok;
    logic [67:0] e;
    seen = 0; busy_ok = 1;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge clk);
      if (resp_valid) seen = 1;
      else if (req_ready) busy_ok = 0;
    end
    n_tests++;
    if (!seen) begin
      n_fail++;
      $display("FAIL resp_wait: no resp_valid within 200 cycles, required one");
      return;
    end
    e = exp_resp_q.pop_front();
    n_tests++;
    if ({resp_code, resp_timeout, resp_rdat} !== e) begin
      n_fail++;
      $display("FAIL resp_fields: got code=%0d to=%0d rdat=%h, required code=%0d to=%0d rdat=%h",
               resp_code, resp_timeout, resp_rdat, e[67:65], e[64], e[63:0]);
    end
    n_tests++;
    if (cyc !== exp_cyc) begin
      n_fail++;
      $display("FAIL resp_cycle: got %0d required %0d", cyc, exp_cyc);
    end
    n_tests++;
    if (req_ready !== 1'b0 || !busy_ok) begin
      n_fail++;
      $display("FAIL ready_busy: req_ready high during operation, required 0");
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL bus_missing: %0d expected accesses not seen, required 0", exp_q.size());
    end
    @(negedge clk);
    n_tests++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL after_done: ready=%0d valid=%0d, required 1 0", req_ready, resp_valid);
    end
    n_tests++;
    if ({resp_code, resp_timeout, resp_rdat} !== e) begin
      n_fail++;
      $display("FAIL resp_hold: got code=%0d rdat=%h, required code=%0d rdat=%h",
               resp_code, resp_rdat, e[67:65], e[63:0]);
    end
  endtask

  task automatic check_stat_spacing(input int exp_n, input int exp_gap);
    n_tests++;
    if (stat_cyc.size() != exp_n) begin
      n_fail++;
      $display("FAIL stat_count: got %0d required %0d", stat_cyc.size(), exp_n);
    end else begin
      for (int i = 1; i < exp_n; i++) begin
        n_tests++;
        if (stat_cyc[i] - stat_cyc[i-1] != exp_gap) begin
          n_fail++;
          $display("FAIL stat_spacing: got %0d required %0d", stat_cyc[i] - stat_cyc[i-1], exp_gap);
        end
      end
    end
  endtask

  // scenarios
  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_tests++;
    if (bus_cs !== 0 || resp_valid !== 0 || resp_code !== 0 || resp_timeout !== 0 || resp_rdat !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: cs=%0d valid=%0d code=%0d to=%0d rdat=%h, required all 0",
               bus_cs, resp_valid, resp_code, resp_timeout, resp_rdat);
    end
    rst_n = 1;
    @(negedge clk);
    n_tests++;
    if (req_ready !== 1'b1 || bus_cs !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ready: ready=%0d cs=%0d, required 1 0", req_ready, bus_cs);
    end
  endtask

  task automatic test_read();
    int n;
    data_mem[0] = 32'h1111_1111; data_mem[1] = 32'h2222_2222;
    stat_q.push_back(32'h2000_0000);
    push_acc(1, CMND_A, 32'h1000_0005);
    push_acc(0, STAT_A, 0);
    push_acc(0, DATA_A, 0);
    push_acc(0, DATA_A + 4, 0);
    exp_resp_q.push_back({3'd1, 1'b0, 64'h2222_2222_1111_1111});
    send_req(4'd1, 3'd5, '0, n);
    wait_resp(n + 8);
  endtask

  task automatic test_nodata_op();
    int n;
    stat_q.push_back(32'h0000_0000);
    push_acc(1, CMND_A, 32'h5000_0007);
    push_acc(0, STAT_A, 0);
    exp_resp_q.push_back({3'd0, 1'b0, 64'd0});
    send_req(4'd5, 3'd7, '0, n);
    wait_resp(n + 4);
  endtask

  task automatic test_write();
    int n;
    stat_q.push_back(32'h2000_0000);
    push_acc(1, DATA_A, 32'hDEAD_BEEF);
    push_acc(1, DATA_A + 4, 32'hCAFE_F00D);
    push_acc(1, CMND_A, 32'h2000_0003);
    push_acc(0, STAT_A, 0);
    exp_resp_q.push_back({3'd1, 1'b0, 64'd0});
    send_req(4'd2, 3'd3, 64'hCAFE_F00D_DEAD_BEEF, n);
    wait_resp(n + 8);
  endtask

  task automatic test_busy_poll();
    int n;
    data_mem[0] = $urandom; data_mem[1] = $urandom;
    stat_cyc.delete();
    repeat (3) stat_q.push_back(32'h6000_0000);
    stat_q.push_back(32'h2000_0000);
    push_acc(1, CMND_A, 32'h1000_0001);
    repeat (4) push_acc(0, STAT_A, 0);
    push_acc(0, DATA_A, 0);
    push_acc(0, DATA_A + 4, 0);
    exp_resp_q.push_back({3'd1, 1'b0, data_mem[1], data_mem[0]});
    send_req(4'd1, 3'd1, '0, n);
    wait_resp(n + 20);
    check_stat_spacing(4, 4);
  endtask

  task automatic test_timeout();
    int n;
    stat_cyc.delete();
    repeat (4) stat_q.push_back(32'h6000_0000);
    push_acc(1, CMND_A, 32'h1000_0002);
    repeat (4) push_acc(0, STAT_A, 0);
    exp_resp_q.push_back({3'd3, 1'b1, 64'd0});
    send_req(4'd1, 3'd2, '0, n);
    wait_resp(n + 16);
    check_stat_spacing(4, 4);
  endtask

  task automatic test_error_code();
    int n;
    stat_q.push_back(32'h4000_0000);
    push_acc(1, CMND_A, 32'h1000_0006);
    push_acc(0, STAT_A, 0);
    exp_resp_q.push_back({3'd2, 1'b0, 64'd0});
    send_req(4'd1, 3'd6, '0, n);
    wait_resp(n + 4);
  endtask

  task automatic test_wait_reset();
    int   n;
    logic seen;
    logic quiet;
    delay_q.push_back(3);
    delay_q.push_back(40);
    push_acc(1, CMND_A, 32'h1000_0004);
    send_req(4'd1, 3'd4, '0, n);
    seen = 0;
    for (int k = 0; k < 50 && !seen; k++) begin
      @(negedge clk);
      if (bus_cs && !bus_we && bus_addr == 16'(STAT_A)) seen = 1;
    end
    n_tests++;
    if (!seen || cyc !== n + 6) begin
      n_fail++;
      $display("FAIL stat_after_wait: seen=%0d cyc=%0d, required 1 %0d", seen, cyc, n + 6);
    end
    @(posedge clk);
    #2 rst_n = 0;
    #1;
    n_tests++;
    if (bus_cs !== 1'b0 || resp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: cs=%0d valid=%0d, required 0 0", bus_cs, resp_valid);
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL cmnd_before_reset: %0d accesses pending, required 0", exp_q.size());
    end
    exp_q.delete(); delay_q.delete(); stat_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    quiet = 1;
    repeat (20) begin
      @(negedge clk);
      if (resp_valid !== 1'b0 || req_ready !== 1'b1 || bus_cs !== 1'b0) quiet = 0;
    end
    n_tests++;
    if (!quiet) begin
      n_fail++;
      $display("FAIL post_reset_quiet: resp_valid/bus_cs active or ready low, required idle");
    end
    // the initiator must work normally again afterwards
    stat_q.push_back(32'h2000_0000);
    push_acc(1, CMND_A, 32'h0000_0000);
    push_acc(0, STAT_A, 0);
    exp_resp_q.push_back({3'd1, 1'b0, 64'd0});
    send_req(4'd0, 3'd0, '0, n);
    wait_resp(n + 4);
  endtask

  initial begin
    test_reset();
    test_read();
    test_nodata_op();
    test_write();
    test_busy_poll();
    test_timeout();
    test_error_code();
    test_wait_reset();
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
